pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 6-stage core: IF1, IF2, ID, EX, MEM, WB.
- Drives the wen/clear inputs of every pipeline register (IF1/IF2, IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC write enable.
- Sequences multi-cycle data-memory handshakes and detects load-use hazards.
- Tracks in-flight instruction fetches so that responses made stale by a redirect are discarded.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 31 +++
 rtl/pipe_hazard_ctrl_if.sv | 59 +++++
 rtl/pipe_hazard_ctrl_load_use_detect.sv | 21 ++
 rtl/pipe_hazard_ctrl.sv | 154 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_hazard_ctrl_pkg;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_fsm_t;

  // Control pair for one pipeline register.
  typedef struct packed {
    logic wen;
    logic clr;
  } stage_ctrl_t;

  localparam int NUM_STAGES  = 5;
  localparam int STG_IF1_IF2 = 0;
  localparam int STG_IF_ID   = 1;
  localparam int STG_ID_EXE  = 2;
  localparam int STG_EXE_MEM = 3;
  localparam int STG_MEM_WB  = 4;

  localparam stage_ctrl_t STAGE_RUN   = '{wen: 1'b1, clr: 1'b0};
  localparam stage_ctrl_t STAGE_RESET = '{wen: 1'b0, clr: 1'b1};

  // True when the ID operand is actually read and names the given register.
  function automatic logic reg_match(input logic uses, input logic [4:0] rs,
                                     input logic [4:0] rd);
    return uses && (rs == rd);
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the core datapath (master) and the hazard sequencer (slave).
//
// Handshakes: dmem_req_valid is held high until the cycle where dmem_ack is
// seen; that cycle completes the access and a new request may follow in the
// next cycle. imem_req_fire marks a fetch accepted by imem in this cycle and
// imem_rsp_valid marks one returned instruction; each pulse counts exactly once.
interface pipe_hazard_ctrl_if #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int PERF_W          = 32
);
  import pipe_hazard_ctrl_pkg::*;

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  // Hazard inputs from the datapath
  logic [4:0]        id_rs1;
  logic [4:0]        id_rs2;
  logic              id_uses_rs1;
  logic              id_uses_rs2;
  logic [4:0]        ex_rd;
  logic              ex_mem_to_reg;
  logic              ex_redirect;
  logic              mem_req;
  logic              dmem_ack;
  logic              imem_req_fire;
  logic              imem_rsp_valid;

  // Pipeline control outputs
  logic              pc_wen;
  logic              if1_if2_wen, if_id_wen, id_exe_wen, exe_mem_wen, mem_wb_wen;
  logic              if1_if2_clr, if_id_clr, id_exe_clr, exe_mem_clr, mem_wb_clr;
  logic              dmem_req_valid;
  logic              imem_drop;
  logic [PERF_W-1:0] stall_cnt;

  // Debug visibility of internal state
  mem_fsm_t          mem_state;
  logic [CNT_W-1:0]  dbg_outstanding;
  logic [CNT_W-1:0]  dbg_drop_cnt;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_to_reg,
           ex_redirect, mem_req, dmem_ack, imem_req_fire, imem_rsp_valid,
    input  pc_wen, if1_if2_wen, if_id_wen, id_exe_wen, exe_mem_wen, mem_wb_wen,
           if1_if2_clr, if_id_clr, id_exe_clr, exe_mem_clr, mem_wb_clr,
           dmem_req_valid, imem_drop, stall_cnt, mem_state, dbg_outstanding,
           dbg_drop_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_mem_to_reg,
           ex_redirect, mem_req, dmem_ack, imem_req_fire, imem_rsp_valid,
    output pc_wen, if1_if2_wen, if_id_wen, id_exe_wen, exe_mem_wen, mem_wb_wen,
           if1_if2_clr, if_id_clr, id_exe_clr, exe_mem_clr, mem_wb_clr,
           dmem_req_valid, imem_drop, stall_cnt, mem_state, dbg_outstanding,
           dbg_drop_cnt
  );

endinterface

// File: rtl/pipe_hazard_ctrl_load_use_detect.sv
// Flags a load in EX whose destination is read by the instruction in ID.
module load_use_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic       ex_mem_to_reg,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  output logic       hazard
);

  // x0 is never a real dependency, so a load targeting it cannot stall.
  always_comb begin
    hazard = ex_mem_to_reg && (ex_rd != 5'd0) &&
             (reg_match(id_uses_rs1, id_rs1, ex_rd) ||
              reg_match(id_uses_rs2, id_rs2, ex_rd));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 6-stage pipeline
// (IF1, IF2, ID, EX, MEM, WB). All control outputs are combinational from
// the current state and inputs; state advances on the rising clock edge.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int PERF_W          = 32
) (
  input logic               clk,
  input logic               reset,
  pipe_hazard_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  mem_fsm_t          state;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  outstanding_next;
  logic [CNT_W-1:0]  drop_cnt;
  logic [PERF_W-1:0] stall_cnt;

  logic        load_use;
  logic        mem_stall;
  logic        redirect_eff;
  logic        fetch_limit;
  logic        load_use_eff;
  logic        any_stall;
  logic        drop;
  stage_ctrl_t stage [NUM_STAGES];
  logic        pc_wen;

  load_use_detect u_load_use (
    .ex_mem_to_reg (bus.ex_mem_to_reg),
    .ex_rd         (bus.ex_rd),
    .id_rs1        (bus.id_rs1),
    .id_rs2        (bus.id_rs2),
    .id_uses_rs1   (bus.id_uses_rs1),
    .id_uses_rs2   (bus.id_uses_rs2),
    .hazard        (load_use)
  );

  // Resolve hazard conditions in priority order: memory wait, redirect,
  // fetch limit, load-use. A redirect seen during a memory stall is left
  // pending because EX is frozen and keeps presenting it.
  always_comb begin
    mem_stall    = !reset && !bus.dmem_ack &&
                   ((state == MEM_WAIT) || bus.mem_req);
    redirect_eff = !reset && !mem_stall && bus.ex_redirect;
    fetch_limit  = !reset && !mem_stall && !bus.ex_redirect &&
                   (outstanding == CNT_MAX) && !bus.imem_rsp_valid;
    load_use_eff = !reset && !mem_stall && !bus.ex_redirect && load_use;
    any_stall    = mem_stall || fetch_limit || load_use_eff;
    drop         = !reset && bus.imem_rsp_valid && (drop_cnt != '0);
  end

  // Build per-stage wen/clr and the PC enable from the resolved conditions.
  always_comb begin
    pc_wen = 1'b1;
    for (int i = 0; i < NUM_STAGES; i++) stage[i] = STAGE_RUN;
    if (reset) begin
      pc_wen = 1'b0;
      for (int i = 0; i < NUM_STAGES; i++) stage[i] = STAGE_RESET;
    end else if (mem_stall) begin
      // Freeze everything up to EX/MEM; WB receives a bubble.
      pc_wen = 1'b0;
      for (int i = 0; i < STG_MEM_WB; i++) stage[i].wen = 1'b0;
      stage[STG_MEM_WB].clr = 1'b1;
    end else if (redirect_eff) begin
      stage[STG_IF1_IF2].clr = 1'b1;
      stage[STG_IF_ID].clr   = 1'b1;
      stage[STG_ID_EXE].clr  = 1'b1;
    end else begin
      if (fetch_limit) begin
        pc_wen = 1'b0;
        stage[STG_IF1_IF2].clr = 1'b1;
      end
      if (load_use_eff) begin
        // Hold PC, IF1/IF2 and IF/ID; let the load advance past a bubble.
        pc_wen = 1'b0;
        stage[STG_IF1_IF2].wen = 1'b0;
        stage[STG_IF_ID].wen   = 1'b0;
        stage[STG_ID_EXE].clr  = 1'b1;
      end else if (drop) begin
        // A stale response must not land in IF/ID.
        stage[STG_IF_ID].clr = 1'b1;
      end
    end
  end

  // Next outstanding-fetch count, kept inside 0..MAX_OUTSTANDING.
  always_comb begin
    outstanding_next = outstanding;
    if (bus.imem_req_fire && !bus.imem_rsp_valid && (outstanding != CNT_MAX))
      outstanding_next = outstanding + 1'b1;
    else if (!bus.imem_req_fire && bus.imem_rsp_valid && (outstanding != '0))
      outstanding_next = outstanding - 1'b1;
  end

  // Data-memory handshake FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MEM_IDLE;
    end else begin
      case (state)
        MEM_IDLE: if (bus.mem_req && !bus.dmem_ack) state <= MEM_WAIT;
        MEM_WAIT: if (bus.dmem_ack) state <= MEM_IDLE;
        default:  state <= MEM_IDLE;
      endcase
    end
  end

  // Fetch tracking: a redirect marks every fetch still in flight as stale.
  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (redirect_eff)
        drop_cnt <= outstanding_next;
      else if (drop)
        drop_cnt <= drop_cnt - 1'b1;
    end
  end

  // Saturating count of stalled cycles; redirect cycles are not stalls.
  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if (any_stall && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 1'b1;
  end

  assign bus.pc_wen          = pc_wen;
  assign bus.if1_if2_wen     = stage[STG_IF1_IF2].wen;
  assign bus.if_id_wen       = stage[STG_IF_ID].wen;
  assign bus.id_exe_wen      = stage[STG_ID_EXE].wen;
  assign bus.exe_mem_wen     = stage[STG_EXE_MEM].wen;
  assign bus.mem_wb_wen      = stage[STG_MEM_WB].wen;
  assign bus.if1_if2_clr     = stage[STG_IF1_IF2].clr;
  assign bus.if_id_clr       = stage[STG_IF_ID].clr;
  assign bus.id_exe_clr      = stage[STG_ID_EXE].clr;
  assign bus.exe_mem_clr     = stage[STG_EXE_MEM].clr;
  assign bus.mem_wb_clr      = stage[STG_MEM_WB].clr;
  assign bus.dmem_req_valid  = !reset && ((state == MEM_WAIT) || bus.mem_req);
  assign bus.imem_drop       = drop;
  assign bus.stall_cnt       = stall_cnt;
  assign bus.mem_state       = state;
  assign bus.dbg_outstanding = outstanding;
  assign bus.dbg_drop_cnt    = drop_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. Inputs change 1ns after the rising
// edge; outputs are sampled on the falling edge.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  // ctrl = {pc_wen, wen[if1_if2,if_id,id_exe,exe_mem,mem_wb], clr[same order]}
  localparam logic [10:0] C_NORMAL = 11'b1_11111_00000;
  localparam logic [10:0] C_RESET  = 11'b0_00000_11111;
  localparam logic [10:0] C_MEMSTL = 11'b0_00001_00001;
  localparam logic [10:0] C_REDIR  = 11'b1_11111_11100;
  localparam logic [10:0] C_LDUSE  = 11'b0_00111_00100;
  localparam logic [10:0] C_FLIMIT = 11'b0_11111_10000;
  localparam logic [10:0] C_DROP   = 11'b1_11111_01000;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  pipe_hazard_ctrl_if #(.MAX_OUTSTANDING(2), .PERF_W(32)) bus ();

  pipe_hazard_ctrl #(.MAX_OUTSTANDING(2), .PERF_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [10:0] ctrl;
  assign ctrl = {bus.pc_wen, bus.if1_if2_wen, bus.if_id_wen, bus.id_exe_wen,
                 bus.exe_mem_wen, bus.mem_wb_wen, bus.if1_if2_clr, bus.if_id_clr,
                 bus.id_exe_clr, bus.exe_mem_clr, bus.mem_wb_clr};

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_idle();
    bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0;
    bus.id_uses_rs1 = 1'b0; bus.id_uses_rs2 = 1'b0;
    bus.ex_rd = 5'd0; bus.ex_mem_to_reg = 1'b0; bus.ex_redirect = 1'b0;
    bus.mem_req = 1'b0; bus.dmem_ack = 1'b0;
    bus.imem_req_fire = 1'b0; bus.imem_rsp_valid = 1'b0;
  endtask

  task automatic set_load(input logic [4:0] rd, input logic [4:0] rs1,
                          input logic u1, input logic [4:0] rs2, input logic u2);
    bus.ex_mem_to_reg = 1'b1; bus.ex_rd = rd;
    bus.id_rs1 = rs1; bus.id_uses_rs1 = u1;
    bus.id_rs2 = rs2; bus.id_uses_rs2 = u2;
  endtask

  task automatic set_fetch(input logic fire, input logic rsp);
    bus.imem_req_fire = fire; bus.imem_rsp_valid = rsp;
  endtask

  task automatic set_mem(input logic req, input logic ack);
    bus.mem_req = req; bus.dmem_ack = ack;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    set_idle();

    // Reset
    reset = 1'b1;
    sample();
    check("reset_ctrl", 64'(ctrl), 64'(C_RESET));
    check("reset_dmem_valid", 64'(bus.dmem_req_valid), 64'd0);
    check("reset_imem_drop", 64'(bus.imem_drop), 64'd0);
    next_cycle();
    reset = 1'b0;
    sample();
    check("idle_ctrl", 64'(ctrl), 64'(C_NORMAL));
    check("idle_stall_cnt", 64'(bus.stall_cnt), 64'd0);
    check("idle_state", 64'(bus.mem_state), 64'(MEM_IDLE));

    // Load-use via rs1, lasts one cycle
    next_cycle(); set_load(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    sample();
    check("lu_rs1_ctrl", 64'(ctrl), 64'(C_LDUSE));
    next_cycle(); set_idle();
    sample();
    check("lu_rs1_after_ctrl", 64'(ctrl), 64'(C_NORMAL));
    check("lu_rs1_stall_cnt", 64'(bus.stall_cnt), 64'd1);

    // Load-use via rs2
    next_cycle(); set_load(5'd7, 5'd0, 1'b0, 5'd7, 1'b1);
    sample();
    check("lu_rs2_ctrl", 64'(ctrl), 64'(C_LDUSE));

    // Negative cases: rd = x0, operand not used, not a load
    next_cycle(); set_load(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    sample();
    check("lu_rd0_ctrl", 64'(ctrl), 64'(C_NORMAL));
    check("lu_rs2_stall_cnt", 64'(bus.stall_cnt), 64'd2);
    next_cycle(); set_load(5'd9, 5'd9, 1'b0, 5'd9, 1'b0);
    sample();
    check("lu_unused_ctrl", 64'(ctrl), 64'(C_NORMAL));
    next_cycle(); set_load(5'd9, 5'd9, 1'b1, 5'd0, 1'b0); bus.ex_mem_to_reg = 1'b0;
    sample();
    check("lu_notload_ctrl", 64'(ctrl), 64'(C_NORMAL));
    next_cycle(); set_idle();
    sample();
    check("lu_neg_stall_cnt", 64'(bus.stall_cnt), 64'd2);

    // Memory wait: three stalled cycles, then ack
    for (int i = 0; i < 3; i++) begin
      next_cycle(); set_mem(1'b1, 1'b0);
      sample();
      check($sformatf("memw_valid_%0d", i), 64'(bus.dmem_req_valid), 64'd1);
      check($sformatf("memw_ctrl_%0d", i), 64'(ctrl), 64'(C_MEMSTL));
    end
    next_cycle(); set_mem(1'b1, 1'b1);
    sample();
    check("memw_ack_valid", 64'(bus.dmem_req_valid), 64'd1);
    check("memw_ack_ctrl", 64'(ctrl), 64'(C_NORMAL));
    check("memw_ack_state", 64'(bus.mem_state), 64'(MEM_WAIT));
    next_cycle(); set_mem(1'b0, 1'b0);
    sample();
    check("memw_done_state", 64'(bus.mem_state), 64'(MEM_IDLE));
    check("memw_done_valid", 64'(bus.dmem_req_valid), 64'd0);
    check("memw_stall_cnt", 64'(bus.stall_cnt), 64'd5);

    // Zero-wait access
    next_cycle(); set_mem(1'b1, 1'b1);
    sample();
    check("mem0_valid", 64'(bus.dmem_req_valid), 64'd1);
    check("mem0_ctrl", 64'(ctrl), 64'(C_NORMAL));
    next_cycle(); set_mem(1'b0, 1'b0);
    sample();
    check("mem0_state", 64'(bus.mem_state), 64'(MEM_IDLE));
    check("mem0_stall_cnt", 64'(bus.stall_cnt), 64'd5);

    // Redirect with two fetches in flight
    next_cycle(); set_fetch(1'b1, 1'b0);
    next_cycle(); set_fetch(1'b1, 1'b0);
    next_cycle(); set_fetch(1'b0, 1'b0); bus.ex_redirect = 1'b1;
    sample();
    check("redir_outstanding", 64'(bus.dbg_outstanding), 64'd2);
    check("redir_ctrl", 64'(ctrl), 64'(C_REDIR));
    next_cycle(); bus.ex_redirect = 1'b0; set_fetch(1'b0, 1'b1);
    sample();
    check("redir_drop_cnt", 64'(bus.dbg_drop_cnt), 64'd2);
    check("redir_drop1", 64'(bus.imem_drop), 64'd1);
    check("redir_drop1_ctrl", 64'(ctrl), 64'(C_DROP));
    next_cycle();
    sample();
    check("redir_drop2", 64'(bus.imem_drop), 64'd1);
    next_cycle(); set_fetch(1'b1, 1'b0);
    next_cycle(); set_fetch(1'b0, 1'b1);
    sample();
    check("redir_drop3", 64'(bus.imem_drop), 64'd0);
    check("redir_drop3_ctrl", 64'(ctrl), 64'(C_NORMAL));
    check("redir_stall_cnt", 64'(bus.stall_cnt), 64'd5);

    // Fetch limit: two fires, no response
    next_cycle(); set_fetch(1'b1, 1'b0);
    sample();
    check("flim_start_outstanding", 64'(bus.dbg_outstanding), 64'd0);
    next_cycle(); set_fetch(1'b1, 1'b0);
    sample();
    check("flim_one_ctrl", 64'(ctrl), 64'(C_NORMAL));
    for (int i = 0; i < 2; i++) begin
      next_cycle(); set_fetch(1'b0, 1'b0);
      sample();
      check($sformatf("flim_ctrl_%0d", i), 64'(ctrl), 64'(C_FLIMIT));
    end
    next_cycle(); set_fetch(1'b0, 1'b1);
    sample();
    check("flim_rsp_ctrl", 64'(ctrl), 64'(C_NORMAL));
    check("flim_stall_cnt", 64'(bus.stall_cnt), 64'd7);
    next_cycle(); set_fetch(1'b0, 1'b1);
    next_cycle(); set_fetch(1'b0, 1'b0);
    sample();
    check("flim_drained", 64'(bus.dbg_outstanding), 64'd0);

    // Redirect held during MEM_WAIT, ack on the fourth cycle
    for (int i = 0; i < 3; i++) begin
      next_cycle(); set_mem(1'b1, 1'b0); bus.ex_redirect = 1'b1;
      sample();
      check($sformatf("rdmem_ctrl_%0d", i), 64'(ctrl), 64'(C_MEMSTL));
    end
    next_cycle(); set_mem(1'b1, 1'b1);
    sample();
    check("rdmem_ack_ctrl", 64'(ctrl), 64'(C_REDIR));
    next_cycle(); set_idle();
    sample();
    check("rdmem_after_ctrl", 64'(ctrl), 64'(C_NORMAL));
    check("rdmem_stall_cnt", 64'(bus.stall_cnt), 64'd10);

    // Reset in the middle of MEM_WAIT
    next_cycle(); set_mem(1'b1, 1'b0);
    next_cycle();
    sample();
    check("rstw_state", 64'(bus.mem_state), 64'(MEM_WAIT));
    check("rstw_stall_cnt", 64'(bus.stall_cnt), 64'd11);
    next_cycle(); reset = 1'b1; set_fetch(1'b1, 1'b0);
    sample();
    check("rstw_ctrl", 64'(ctrl), 64'(C_RESET));
    check("rstw_valid", 64'(bus.dmem_req_valid), 64'd0);
    check("rstw_drop", 64'(bus.imem_drop), 64'd0);
    next_cycle(); reset = 1'b0; set_idle();
    sample();
    check("rstw_after_state", 64'(bus.mem_state), 64'(MEM_IDLE));
    check("rstw_after_stall_cnt", 64'(bus.stall_cnt), 64'd0);
    check("rstw_after_outstanding", 64'(bus.dbg_outstanding), 64'd0);
    check("rstw_after_drop_cnt", 64'(bus.dbg_drop_cnt), 64'd0);
    check("rstw_after_ctrl", 64'(ctrl), 64'(C_NORMAL));

    // Report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
